hazard_ctrl: RTL and testbench

- Pipeline hazard and stall controller for the 5-stage RV32 core.
- Sequences the IF/ID, ID/EX, EX/MEM and MEM/WB registers with stall/flush strobes.
- Generates EX-stage operand forwarding selects, detects load-use and control hazards, and runs a data-memory wait/timeout FSM.
- Keeps saturating stall/flush event counters.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_fwd_sel.sv | 29 ++
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the RV32 pipeline hazard controller: forward selects,
// the load result-source encoding and the data-memory wait FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// EX-stage operand forward select for one source register; purely combinational,
// no latency and no backpressure. MEM beats WB, and x0 is never forwarded.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr_m,
  input  logic                  regwrite_m,
  input  logic [ADDR_WIDTH-1:0] rd_addr_w,
  input  logic                  regwrite_w,
  output logic [1:0]            fwd_sel
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_RF;
    if (regwrite_m && (rd_addr_m == rs_addr) && (rd_addr_m != '0)) begin
      sel = FWD_MEM;
    end else if (regwrite_w && (rd_addr_w == rs_addr) && (rd_addr_w != '0)) begin
      sel = FWD_WB;
    end
  end

  assign fwd_sel = sel;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control for the 5-stage core plus data-memory wait FSM.
// Strobes are combinational; timeout pulse and event counters lag one cycle.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int MAX_WAIT   = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_rs1_addr_d,
  input  logic [ADDR_WIDTH-1:0] i_rs2_addr_d,
  input  logic [ADDR_WIDTH-1:0] i_rs1_addr_e,
  input  logic [ADDR_WIDTH-1:0] i_rs2_addr_e,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_e,
  input  logic [1:0]            i_resultsrc_e,
  input  logic                  i_pcsrc_e,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_m,
  input  logic                  i_regwrite_m,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_w,
  input  logic                  i_regwrite_w,
  input  logic                  i_dmem_req_m,
  input  logic                  i_dmem_ack,
  output logic [1:0]            o_forward_a_e,
  output logic [1:0]            o_forward_b_e,
  output logic                  o_stall_f,
  output logic                  o_stall_d,
  output logic                  o_stall_e,
  output logic                  o_stall_m,
  output logic                  o_flush_d,
  output logic                  o_flush_e,
  output logic                  o_flush_w,
  output logic                  o_dmem_timeout,
  output logic [CNT_WIDTH-1:0]  o_stall_cnt,
  output logic [CNT_WIDTH-1:0]  o_flush_cnt
);

  localparam int                WCNT_W    = $clog2(MAX_WAIT);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  mem_state_e        state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              timeout_now;
  logic              mem_stall;
  logic              load_use;
  logic              ctrl_flush;
  logic [1:0]        fwd_a, fwd_b;

  hazard_fwd_sel #(.ADDR_WIDTH(ADDR_WIDTH)) u_fwd_a (
    .rs_addr    (i_rs1_addr_e),
    .rd_addr_m  (i_rd_addr_m),
    .regwrite_m (i_regwrite_m),
    .rd_addr_w  (i_rd_addr_w),
    .regwrite_w (i_regwrite_w),
    .fwd_sel    (fwd_a)
  );

  hazard_fwd_sel #(.ADDR_WIDTH(ADDR_WIDTH)) u_fwd_b (
    .rs_addr    (i_rs2_addr_e),
    .rd_addr_m  (i_rd_addr_m),
    .regwrite_m (i_regwrite_m),
    .rd_addr_w  (i_rd_addr_w),
    .regwrite_w (i_regwrite_w),
    .fwd_sel    (fwd_b)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wcnt_nxt    = wcnt;
    timeout_now = 1'b0;
    case (state)
      IDLE: begin
        if (i_dmem_req_m && !i_dmem_ack) begin
          state_nxt = WAIT;
          wcnt_nxt  = WCNT_W'(1);
        end
      end
      WAIT: begin
        if (!i_dmem_req_m || i_dmem_ack) begin
          state_nxt = IDLE;
          wcnt_nxt  = '0;
        end else if (wcnt == WCNT_LAST) begin
          // Give up: release the pipeline and let the access retire without data.
          timeout_now = 1'b1;
          state_nxt   = IDLE;
          wcnt_nxt    = '0;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A memory stall freezes EX, so its load-use/branch hazards wait until release.
  assign mem_stall  = i_rst_n & i_dmem_req_m & ~i_dmem_ack & ~timeout_now;
  assign ctrl_flush = i_rst_n & ~mem_stall & i_pcsrc_e;
  assign load_use   = i_rst_n & ~mem_stall & (i_resultsrc_e == RESULTSRC_LOAD) &
                      (i_rd_addr_e != '0) &
                      ((i_rd_addr_e == i_rs1_addr_d) | (i_rd_addr_e == i_rs2_addr_d));

  assign o_stall_f = mem_stall | (load_use & ~ctrl_flush);
  assign o_stall_d = mem_stall | (load_use & ~ctrl_flush);
  assign o_stall_e = mem_stall;
  assign o_stall_m = mem_stall;
  assign o_flush_d = ~i_rst_n | ctrl_flush;
  assign o_flush_e = ~i_rst_n | ctrl_flush | load_use;
  assign o_flush_w = ~i_rst_n | mem_stall;

  assign o_forward_a_e = i_rst_n ? fwd_a : FWD_RF;
  assign o_forward_b_e = i_rst_n ? fwd_b : FWD_RF;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_dmem_timeout <= 1'b0;
      o_stall_cnt    <= '0;
      o_flush_cnt    <= '0;
    end else begin
      o_dmem_timeout <= timeout_now;
      if (o_stall_f && (o_stall_cnt != CNT_MAX)) begin
        o_stall_cnt <= o_stall_cnt + 1'b1;
      end
      if (ctrl_flush && (o_flush_cnt != CNT_MAX)) begin
        o_flush_cnt <= o_flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: forwarding, load-use, branch flush,
// memory wait/ack/timeout/drop, counter saturation and mid-wait reset.
module tb_hazard_ctrl;
  localparam int AW = 5;
  localparam int MW = 4;
  localparam int CW = 3;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic [3:0] st;
    logic [2:0] fl;
    logic       to;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0]    rsrc;
  logic          pcsrc, rwm, rww, req, ack;
  logic [1:0]    fwd_a, fwd_b;
  logic          stall_f, stall_d, stall_e, stall_m;
  logic          flush_d, flush_e, flush_w, tmo;
  logic [CW-1:0] stall_cnt, flush_cnt;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  hazard_ctrl #(.ADDR_WIDTH(AW), .MAX_WAIT(MW), .CNT_WIDTH(CW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_rs1_addr_d   (rs1_d),
    .i_rs2_addr_d   (rs2_d),
    .i_rs1_addr_e   (rs1_e),
    .i_rs2_addr_e   (rs2_e),
    .i_rd_addr_e    (rd_e),
    .i_resultsrc_e  (rsrc),
    .i_pcsrc_e      (pcsrc),
    .i_rd_addr_m    (rd_m),
    .i_regwrite_m   (rwm),
    .i_rd_addr_w    (rd_w),
    .i_regwrite_w   (rww),
    .i_dmem_req_m   (req),
    .i_dmem_ack     (ack),
    .o_forward_a_e  (fwd_a),
    .o_forward_b_e  (fwd_b),
    .o_stall_f      (stall_f),
    .o_stall_d      (stall_d),
    .o_stall_e      (stall_e),
    .o_stall_m      (stall_m),
    .o_flush_d      (flush_d),
    .o_flush_e      (flush_e),
    .o_flush_w      (flush_w),
    .o_dmem_timeout (tmo),
    .o_stall_cnt    (stall_cnt),
    .o_flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0;
    rd_m = '0; rd_w = '0; rsrc = 2'b00; pcsrc = 1'b0;
    rwm = 1'b0; rww = 1'b0; req = 1'b0; ack = 1'b0;
  endtask

  // Expected outputs for the current input set are queued, then popped and
  // compared once the DUT outputs have settled mid-cycle.
  task automatic cyc(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                     input logic [3:0] st, input logic [2:0] fl, input logic to,
                     input int sc, input int fc);
    exp_t e;
    e.fa = fa; e.fb = fb; e.st = st; e.fl = fl; e.to = to;
    e.sc = CW'(sc); e.fc = CW'(fc);
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, ".fwd_a"}, 32'(fwd_a), 32'(e.fa));
    chk({tag, ".fwd_b"}, 32'(fwd_b), 32'(e.fb));
    chk({tag, ".stall"}, 32'({stall_f, stall_d, stall_e, stall_m}), 32'(e.st));
    chk({tag, ".flush"}, 32'({flush_d, flush_e, flush_w}), 32'(e.fl));
    chk({tag, ".tmo"}, 32'(tmo), 32'(e.to));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e.sc));
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(e.fc));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    rd_m = 5; rwm = 1'b1; rs1_e = 5; rs2_e = 5; req = 1'b1; pcsrc = 1'b1;
    @(posedge clk);
    #1;
    cyc("rst", 2'b00, 2'b00, 4'b0000, 3'b111, 1'b0, 0, 0);
    rst_n = 1'b1;
    idle();
    cyc("idle", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 0, 0);

    // forwarding
    rd_m = 5; rwm = 1'b1; rd_w = 5; rww = 1'b1; rs1_e = 5; rs2_e = 7;
    cyc("fwd_mem", 2'b10, 2'b00, 4'b0000, 3'b000, 1'b0, 0, 0);
    rd_m = 0; rs2_e = 0;
    cyc("fwd_x0m", 2'b01, 2'b00, 4'b0000, 3'b000, 1'b0, 0, 0);
    rd_m = 5; rwm = 1'b0; rd_w = 6; rs2_e = 6;
    cyc("fwd_nowr", 2'b00, 2'b01, 4'b0000, 3'b000, 1'b0, 0, 0);
    rwm = 1'b1; rd_m = 6; rs1_e = 6;
    cyc("fwd_both", 2'b10, 2'b10, 4'b0000, 3'b000, 1'b0, 0, 0);
    idle();

    // load-use
    rsrc = 2'b01; rd_e = 6; rs1_d = 3; rs2_d = 6;
    cyc("lu", 2'b00, 2'b00, 4'b1100, 3'b010, 1'b0, 0, 0);
    idle();
    cyc("lu_after", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1, 0);
    rsrc = 2'b01; rd_e = 0; rs1_d = 0; rs2_d = 0;
    cyc("lu_x0", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1, 0);
    rsrc = 2'b00; rd_e = 6; rs1_d = 6;
    cyc("nonload", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1, 0);

    // branch beats load-use
    rsrc = 2'b01; rd_e = 6; rs1_d = 6; pcsrc = 1'b1;
    cyc("br_lu", 2'b00, 2'b00, 4'b0000, 3'b110, 1'b0, 1, 0);
    idle();
    cyc("br_after", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1, 1);

    // memory wait acked on the last allowed cycle; load-use hidden by the stall
    req = 1'b1; rsrc = 2'b01; rd_e = 6; rs1_d = 6;
    cyc("w0", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 1, 1);
    idle(); req = 1'b1;
    cyc("w1", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 2, 1);
    cyc("w2", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 3, 1);
    ack = 1'b1;
    cyc("w_ack", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 4, 1);
    idle();
    cyc("w_done", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 4, 1);
    req = 1'b1; ack = 1'b1;
    cyc("zero_wait", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 4, 1);
    idle();

    // timeout with a branch held in EX
    req = 1'b1; pcsrc = 1'b1;
    cyc("t0", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 4, 1);
    cyc("t1", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 5, 1);
    cyc("t2", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 6, 1);
    cyc("t3", 2'b00, 2'b00, 4'b0000, 3'b110, 1'b0, 7, 1);
    idle();
    cyc("t_pulse", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b1, 7, 2);
    cyc("t_clr", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 7, 2);

    // request dropped mid-wait; stall counter stays saturated
    req = 1'b1;
    cyc("d0", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 7, 2);
    idle();
    cyc("d_drop", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 7, 2);
    cyc("d_noto", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 7, 2);

    // reset in the middle of a wait
    req = 1'b1;
    cyc("r0", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 7, 2);
    rst_n = 1'b0;
    rd_m = 5; rwm = 1'b1; rs1_e = 5; pcsrc = 1'b1; rsrc = 2'b01; rd_e = 6; rs1_d = 6;
    cyc("r_in", 2'b00, 2'b00, 4'b0000, 3'b111, 1'b0, 7, 2);
    cyc("r_clr", 2'b00, 2'b00, 4'b0000, 3'b111, 1'b0, 0, 0);
    rst_n = 1'b1;
    idle(); req = 1'b1;
    cyc("r1", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 0, 0);
    cyc("r2", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 1, 0);
    cyc("r3", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 2, 0);
    cyc("r4_to", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 3, 0);
    idle();
    cyc("r_pulse", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b1, 3, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
